// File: rtl/address_generation_stage_if.sv
// Handshake bundles around the address generation stage.
// ags_req_if: upstream entry + in_valid/in_ready. ags_rsp_if: memory-op + out_valid/out_ready.
interface ags_req_if #(
  parameter int ADDR_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic              mem_access;
  logic [ADDR_W-1:0] seg_base;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] index;
  logic [1:0]        scale;
  logic [ADDR_W-1:0] disp;
  logic [1:0]        data_size;
  logic [31:0]       EIP;
  logic [15:0]       CS;
  logic [31:0]       control_store;
  logic [2:0]        DR;
  logic [2:0]        SR;
  logic [2:0]        MM_DR;
  logic [2:0]        SEG_ID;
  logic [31:0]       A;
  logic [31:0]       B;
  logic [63:0]       MM_A;
  logic [63:0]       MM_B;
  logic              operation;
  logic              MM_operation;

  modport master (
    output in_valid, mem_access, seg_base, base, index,
    output scale, disp, data_size,
    output EIP, CS, control_store, DR, SR, MM_DR, SEG_ID,
    output A, B, MM_A, MM_B, operation, MM_operation,
    input  in_ready
  );

  modport slave (
    input  in_valid, mem_access, seg_base, base, index,
    input  scale, disp, data_size,
    input  EIP, CS, control_store, DR, SR, MM_DR, SEG_ID,
    input  A, B, MM_A, MM_B, operation, MM_operation,
    output in_ready
  );
endinterface

interface ags_rsp_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_B = 8
);
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] address_OUT;
  logic [LINE_B-1:0] byte_mask_OUT;
  logic [1:0]        part_OUT;
  logic [31:0]       EIP_OUT;
  logic [15:0]       CS_OUT;
  logic [31:0]       control_store_OUT;
  logic [2:0]        DR_OUT;
  logic [2:0]        SR_OUT;
  logic [2:0]        MM_DR_OUT;
  logic [2:0]        SEG_ID_OUT;
  logic [31:0]       A_OUT;
  logic [31:0]       B_OUT;
  logic [63:0]       MM_A_OUT;
  logic [63:0]       MM_B_OUT;
  logic              operation_OUT;
  logic              MM_operation_OUT;

  modport master (
    output out_valid, address_OUT, byte_mask_OUT, part_OUT,
    output EIP_OUT, CS_OUT, control_store_OUT,
    output DR_OUT, SR_OUT, MM_DR_OUT, SEG_ID_OUT,
    output A_OUT, B_OUT, MM_A_OUT, MM_B_OUT,
    output operation_OUT, MM_operation_OUT,
    input  out_ready
  );

  modport slave (
    input  out_valid, address_OUT, byte_mask_OUT, part_OUT,
    input  EIP_OUT, CS_OUT, control_store_OUT,
    input  DR_OUT, SR_OUT, MM_DR_OUT, SEG_ID_OUT,
    input  A_OUT, B_OUT, MM_A_OUT, MM_B_OUT,
    input  operation_OUT, MM_operation_OUT,
    output out_ready
  );
endinterface

// File: rtl/address_generation_stage.sv
// Address generation stage: linear address, dcache byte mask, line-split.
// Ports: clk, reset (async, low), flush, i_req (upstream), o_rsp (to memory stage).
module address_generation_stage #(
  parameter int ADDR_W = 32,
  parameter int LINE_B = 8
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      flush,
  ags_req_if.slave  i_req,
  ags_rsp_if.master o_rsp
);
  localparam int OFF_W = $clog2(LINE_B);
  localparam int NB_W  = OFF_W + 1;
  localparam int MW    = 2 * LINE_B;
  localparam int LW    = ADDR_W - OFF_W;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_FULL,
    S_SPLIT_LO,
    S_SPLIT_HI
  } state_t;

  typedef struct packed {
    logic [31:0] eip;
    logic [15:0] cs;
    logic [31:0] cstore;
    logic [2:0]  dr;
    logic [2:0]  sr;
    logic [2:0]  mm_dr;
    logic [2:0]  seg_id;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] mm_a;
    logic [63:0] mm_b;
    logic        op;
    logic        mm_op;
  } sb_t;

  state_t            r_state;
  state_t            w_next;
  state_t            w_cap;
  logic [ADDR_W-1:0] w_lin;
  logic [ADDR_W-1:0] r_lin;
  logic [NB_W-1:0]   w_nbytes;
  logic [NB_W-1:0]   w_end;
  logic [MW-1:0]     w_mask;
  logic [MW-1:0]     r_mask;
  logic              r_mem;
  logic              w_cross;
  logic              w_acc;
  logic              w_in_ready;
  logic [LW-1:0]     w_line_inc;
  logic [ADDR_W-1:0] w_hi_addr;
  sb_t               w_sb;
  sb_t               r_sb;
  logic              w_valid;
  logic [ADDR_W-1:0] w_addr;
  logic [LINE_B-1:0] w_bmask;
  logic [1:0]        w_part;

  assign w_lin = i_req.seg_base + i_req.base
               + (i_req.index << i_req.scale)
               + i_req.disp;

  assign w_nbytes = NB_W'(1) << i_req.data_size;

  // Mask spans two lines; upper half feeds the high op of a split.
  assign w_mask = ((MW'(1) << w_nbytes) - MW'(1))
                  << w_lin[OFF_W-1:0];

  assign w_end   = NB_W'(w_lin[OFF_W-1:0]) + w_nbytes;
  assign w_cross = i_req.mem_access
                 & (w_end > NB_W'(LINE_B));
  assign w_cap   = w_cross ? S_SPLIT_LO : S_FULL;

  assign w_sb = {
    i_req.EIP, i_req.CS, i_req.control_store,
    i_req.DR, i_req.SR, i_req.MM_DR, i_req.SEG_ID,
    i_req.A, i_req.B, i_req.MM_A, i_req.MM_B,
    i_req.operation, i_req.MM_operation
  };

  always_comb begin
    w_in_ready = 1'b0;
    unique case (r_state)
      S_EMPTY:            w_in_ready = 1'b1;
      S_FULL, S_SPLIT_HI: w_in_ready = o_rsp.out_ready;
      default:            w_in_ready = 1'b0;
    endcase
  end

  assign i_req.in_ready = w_in_ready;
  assign w_acc = i_req.in_valid & w_in_ready & ~flush;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_EMPTY: begin
        if (i_req.in_valid) w_next = w_cap;
      end
      S_FULL, S_SPLIT_HI: begin
        if (o_rsp.out_ready)
          w_next = i_req.in_valid ? w_cap : S_EMPTY;
      end
      S_SPLIT_LO: begin
        if (o_rsp.out_ready) w_next = S_SPLIT_HI;
      end
      default: w_next = S_EMPTY;
    endcase
    if (flush) w_next = S_EMPTY;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_EMPTY;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lin  <= '0;
      r_mask <= '0;
      r_mem  <= 1'b0;
      r_sb   <= '0;
    end else if (w_acc) begin
      r_lin  <= w_lin;
      r_mask <= w_mask;
      r_mem  <= i_req.mem_access;
      r_sb   <= w_sb;
    end
  end

  // Next line base; wraps from the top line to address 0.
  assign w_line_inc = r_lin[ADDR_W-1:OFF_W] + LW'(1);
  assign w_hi_addr  = {w_line_inc, {OFF_W{1'b0}}};

  always_comb begin
    w_valid = 1'b0;
    w_addr  = '0;
    w_bmask = '0;
    w_part  = 2'b00;
    unique case (r_state)
      S_FULL: begin
        w_valid = 1'b1;
        w_addr  = r_lin;
        w_bmask = r_mem ? r_mask[LINE_B-1:0] : '0;
      end
      S_SPLIT_LO: begin
        w_valid = 1'b1;
        w_addr  = r_lin;
        w_bmask = r_mask[LINE_B-1:0];
        w_part  = 2'b01;
      end
      S_SPLIT_HI: begin
        w_valid = 1'b1;
        w_addr  = w_hi_addr;
        w_bmask = r_mask[MW-1:LINE_B];
        w_part  = 2'b10;
      end
      default: ;
    endcase
  end

  assign o_rsp.out_valid        = w_valid;
  assign o_rsp.address_OUT      = w_addr;
  assign o_rsp.byte_mask_OUT    = w_bmask;
  assign o_rsp.part_OUT         = w_part;
  assign o_rsp.EIP_OUT          = r_sb.eip;
  assign o_rsp.CS_OUT           = r_sb.cs;
  assign o_rsp.control_store_OUT = r_sb.cstore;
  assign o_rsp.DR_OUT           = r_sb.dr;
  assign o_rsp.SR_OUT           = r_sb.sr;
  assign o_rsp.MM_DR_OUT        = r_sb.mm_dr;
  assign o_rsp.SEG_ID_OUT       = r_sb.seg_id;
  assign o_rsp.A_OUT            = r_sb.a;
  assign o_rsp.B_OUT            = r_sb.b;
  assign o_rsp.MM_A_OUT         = r_sb.mm_a;
  assign o_rsp.MM_B_OUT         = r_sb.mm_b;
  assign o_rsp.operation_OUT    = r_sb.op;
  assign o_rsp.MM_operation_OUT = r_sb.mm_op;

endmodule

// File: doc/address_generation_stage.md
Name: address_generation_stage

Overview:
- Pipeline stage directly upstream of the memory stage.
- Computes the 32-bit linear address from segment base, base, scaled index and displacement, and builds the 8-byte dcache byte mask.
- Splits any access that crosses an 8-byte dcache line into two back-to-back memory ops.
- Holds one entry in an output pipeline register, with valid/ready handshakes on both sides.

Parameters:
- ADDR_W, 32, address / operand width.
- LINE_B, 8, dcache line width in bytes; fixed at 8 and must be a power of two.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous pipeline flush; drops held entry.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept this cycle.
- mem_access  in  1  entry references memory; 0 = pass-through, no mask, no split.
- seg_base  in  32  base of segment selected by SEG_ID.
- base  in  32  base register value.
- index  in  32  index register value.
- scale  in  2  index shift: 0..3 (x1, x2, x4, x8).
- disp  in  32  sign-extended displacement.
- data_size  in  2  00=1B, 01=2B, 10=4B, 11=8B.
- EIP, CS, control_store, DR, SR, MM_DR, SEG_ID, A, B, MM_A, MM_B, operation, MM_operation  in  32, 16, 32, 3, 3, 3, 3, 32, 32, 64, 64, 1, 1  sideband fields, registered unchanged.
- out_valid  out  1  entry valid toward memory stage.
- out_ready  in  1  memory stage consumes entry this cycle.
- address_OUT  out  32  address of current op.
- byte_mask_OUT  out  8  byte enables within the line.
- part_OUT  out  2  00 = whole, 01 = low half of split, 10 = high half.
- sideband *_OUT  out  as inputs  registered copies of the sideband fields.

Behaviour:
- Linear address: lin = seg_base + base + (index << scale) + disp, modulo 2^32; wrap-around is silent.
- nbytes = 1 << data_size.
- Mask: m16 = ((1 << nbytes) - 1) << lin[2:0], 16 bits wide.
- Crossing condition: cross = mem_access & (lin[2:0] + nbytes > 8).
- FSM states: EMPTY, FULL, SPLIT_LO, SPLIT_HI.
- EMPTY:
  - out_valid=0, in_ready=1.
  - On in_valid, capture the entry and go to SPLIT_LO if cross, else FULL.
- FULL:
  - out_valid=1, address_OUT=lin, part=00.
  - byte_mask = m16[7:0] if mem_access, else 00.
  - in_ready = out_ready.
  - On out_ready: with in_valid, capture the new entry (FULL or SPLIT_LO); without in_valid, go to EMPTY.
- SPLIT_LO:
  - out_valid=1, address_OUT=lin, byte_mask=m16[7:0], part=01.
  - in_ready=0.
  - On out_ready go to SPLIT_HI.
- SPLIT_HI:
  - out_valid=1, address_OUT = {lin[31:3]+1, 3'b000}, modulo 2^32, so 0xFFFFFFF8 line wraps to 0x0.
  - byte_mask = m16[15:8], part=10.
  - in_ready = out_ready.
  - Next-state rules are the same as FULL.
- Sideband outputs hold their captured values for both halves of a split.
- Latency: an entry accepted at edge N is presented at cycle N+1. A split occupies at least two output cycles.
- Hold rule: while out_valid && !out_ready, every output stays stable.
- Flush:
  - Highest priority after reset. Next state is EMPTY and out_valid=0, including mid-split (the high half is discarded).
  - An in_valid in the same cycle is dropped.
  - in_ready is not gated by flush.
- Reset (asserted low, asynchronous): state=EMPTY and out_valid=0.
  - Data outputs reset to 0, part_OUT=00, byte_mask_OUT=00.
  - An in-flight split is abandoned.
- in_ready is combinational from state and out_ready. No combinational path from in_valid to out_valid.

Test Plan:
- Single 4B access: seg_base=0x1000, base=0x20, index=3, scale=2, disp=0x4, mem_access=1, out_ready=1 -> next cycle out_valid=1, address_OUT=0x00001030, byte_mask=0x0F, part=00.
- Split 4B access: lin=0x1006 -> cycle 1 address_OUT=0x1006, mask=0xC0, part=01, in_ready=0. Cycle 2 address_OUT=0x1008, mask=0x03, part=10.
- Wrap: seg_base=0xFFFFFFF0, disp=0x10, others 0, size 8B -> address_OUT=0x00000000, mask=0xFF, no split. Separately, lin=0xFFFFFFFC, 8B -> halves at 0xFFFFFFFC (mask 0xF0) then 0x00000000 (mask 0x0F).
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 held -> outputs stable, in_ready=0. out_ready=1 -> the new entry appears the following cycle, with no bubble and no duplicate.
- Flush during SPLIT_LO -> next cycle out_valid=0, state EMPTY, no high half issued. Async reset low mid-split -> out_valid=0 immediately, all outputs 0.
- Non-memory entry: mem_access=0, lin offset 7, size 8B -> single FULL entry, byte_mask=0x00, part=00.
